tnn_vote_classifier: RTL and testbench



---
 rtl/tnn_vote_classifier.sv | 134 +++++++++++++
 tb/tb_tnn_vote_classifier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_vote_classifier.sv
// Ternary vote classifier: serial per-class accumulation of hidden bits,
// then a serial signed argmax, returned over a valid/ready handshake.
module tnn_vote_classifier #(
  parameter int NUM_HIDDEN  = 6,
  parameter int NUM_CLASSES = 7,
  parameter logic [2*NUM_HIDDEN*NUM_CLASSES-1:0] WEIGHTS = '0,
  localparam int SW = $clog2(NUM_HIDDEN+1) + 1,
  localparam int CW = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_HIDDEN-1:0] hidden_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         class_out,
  output logic [SW-1:0]         score_out
);

  localparam int JW = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(NUM_HIDDEN - 1);
  localparam logic [CW-1:0] K_LAST = CW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_OUT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_HIDDEN-1:0]  r_hidden;
  logic [JW-1:0]          r_j;
  logic [CW-1:0]          r_k;
  logic signed [SW-1:0]   r_acc [NUM_CLASSES];
  logic signed [SW-1:0]   r_best;
  logic [CW-1:0]          r_best_idx;
  logic [CW-1:0]          r_class;
  logic signed [SW-1:0]   r_score;
  logic signed [SW-1:0]   w_cand;
  logic                   w_take;
  logic signed [SW-1:0]   w_best_nxt;
  logic [CW-1:0]          w_idx_nxt;

  // Decode one ternary weight code into a signed vote.
  function automatic logic signed [SW-1:0] wt(
    input int k,
    input int j
  );
    logic [1:0] c;
    c = WEIGHTS[2*(k*NUM_HIDDEN+j) +: 2];
    unique case (c)
      2'b01:   return SW'(1);
      2'b11:   return '1;
      default: return '0;
    endcase
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign class_out = r_class;
  assign score_out = r_score;

  // Argmax step: class 0 seeds the best; later classes must be strictly greater.
  always_comb begin
    w_cand     = r_acc[r_k];
    w_take     = (r_k == '0) || (w_cand > r_best);
    w_best_nxt = w_take ? w_cand : r_best;
    w_idx_nxt  = w_take ? r_k : r_best_idx;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (r_j == J_LAST) w_state_nxt = S_ARGMAX;
      S_ARGMAX: if (r_k == K_LAST) w_state_nxt = S_OUT;
      S_OUT:    if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, accumulate, argmax and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hidden   <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_class    <= '0;
      r_score    <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) r_acc[k] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_hidden <= hidden_in;
            r_j      <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) r_acc[k] <= '0;
          end
        end
        S_ACCUM: begin
          if (r_hidden[r_j]) begin
            for (int k = 0; k < NUM_CLASSES; k++)
              r_acc[k] <= r_acc[k] + wt(k, int'(r_j));
          end
          r_j <= r_j + JW'(1);
          if (r_j == J_LAST) r_k <= '0;
        end
        S_ARGMAX: begin
          r_best     <= w_best_nxt;
          r_best_idx <= w_idx_nxt;
          r_k        <= r_k + CW'(1);
          if (r_k == K_LAST) begin
            r_class <= w_idx_nxt;
            r_score <= w_best_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_vote_classifier.sv
// Bench for tnn_vote_classifier: four weight sets in lockstep,
// directed and random vectors checked against a score/argmax model.
module tb_tnn_vote_classifier;

  localparam int NH = 6;
  localparam int NC = 7;
  localparam int WB = 2*NH*NC;
  localparam int ND = 4;

  function automatic logic [WB-1:0] mkw(input logic [1:0] c6);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < NH; k++) w[2*(k*NH+k) +: 2] = 2'b01;
    for (int j = 0; j < NH; j++) w[2*(6*NH+j) +: 2] = c6;
    return w;
  endfunction

  localparam logic [WB-1:0] W0 = '0;
  localparam logic [WB-1:0] W1 = mkw(2'b11);
  localparam logic [WB-1:0] W2 = mkw(2'b01);
  localparam logic [WB-1:0] W3 = 84'h9_3C5A_F0E1_D2B4_7869_A5C3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [NH-1:0] hidden_in;
  logic ir [ND];
  logic ov [ND];
  logic [2:0] cls [ND];
  logic [3:0] sc [ND];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tnn_vote_classifier #(.WEIGHTS(W0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .hidden_in(hidden_in), .out_valid(ov[0]), .out_ready(out_ready),
    .class_out(cls[0]), .score_out(sc[0]));
  tnn_vote_classifier #(.WEIGHTS(W1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .hidden_in(hidden_in), .out_valid(ov[1]), .out_ready(out_ready),
    .class_out(cls[1]), .score_out(sc[1]));
  tnn_vote_classifier #(.WEIGHTS(W2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .hidden_in(hidden_in), .out_valid(ov[2]), .out_ready(out_ready),
    .class_out(cls[2]), .score_out(sc[2]));
  tnn_vote_classifier #(.WEIGHTS(W3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .hidden_in(hidden_in), .out_valid(ov[3]), .out_ready(out_ready),
    .class_out(cls[3]), .score_out(sc[3]));

  function automatic logic [WB-1:0] wsel(input int d);
    case (d)
      0: return W0;
      1: return W1;
      2: return W2;
      default: return W3;
    endcase
  endfunction

  // Score each class as a plain sum, then pick the first maximum.
  function automatic void model(
    input logic [WB-1:0] w, input logic [NH-1:0] h,
    output int mc, output int ms);
    int s;
    logic [1:0] c;
    mc = 0;
    ms = 0;
    for (int k = 0; k < NC; k++) begin
      s = 0;
      for (int j = 0; j < NH; j++) begin
        c = w[2*(k*NH+j) +: 2];
        if (h[j] && c == 2'b01) s = s + 1;
        if (h[j] && c == 2'b11) s = s - 1;
      end
      if (k == 0 || s > ms) begin
        mc = k;
        ms = s;
      end
    end
  endfunction

  task automatic chk(input string tag,
    input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [NH-1:0] h, input int hold);
    int bad;
    int mc;
    int ms;
    logic [2:0] c0;
    logic [3:0] s0;
    chk("ready_before", 32'(ir[1]), 1);
    in_valid  = 1'b1;
    hidden_in = h;
    tick();
    bad = 0;
    for (int c = 1; c < 13; c++) begin
      in_valid  = 1'($urandom);
      hidden_in = NH'($urandom);
      out_ready = 1'($urandom);
      tick();
      for (int d = 0; d < ND; d++)
        if (ov[d] !== 1'b0 || ir[d] !== 1'b0) bad++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("busy_flags", bad, 0);
    tick();
    chk("latency_valid", 32'(ov[1]), 1);
    for (int d = 0; d < ND; d++) begin
      model(wsel(d), h, mc, ms);
      chk($sformatf("class_d%0d", d), 32'(cls[d]), mc);
      chk($sformatf("score_d%0d", d), 32'($signed(sc[d])), ms);
    end
    c0 = cls[3];
    s0 = sc[3];
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      in_valid  = 1'($urandom);
      hidden_in = NH'($urandom);
      tick();
      if (cls[3] !== c0 || sc[3] !== s0) bad++;
      if (ov[3] !== 1'b1 || ir[3] !== 1'b0) bad++;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_hs", 32'({ov[1], ir[1]}), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hidden_in = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ir[1]), 1);
    chk("rst_valid", 32'(ov[1]), 0);
    chk("rst_class", 32'(cls[1]), 0);
    chk("rst_score", 32'(sc[1]), 0);
    rst_n = 1'b1;
    tick();

    run_vec(6'b111111, 0);
    chk("zero_w_class", 32'(cls[0]), 0);
    chk("zero_w_score", 32'(sc[0]), 0);
    chk("all_pos_class", 32'(cls[2]), 6);
    chk("all_pos_score", 32'($signed(sc[2])), 6);

    run_vec(6'b001000, 0);
    chk("one_hot_class", 32'(cls[1]), 3);
    chk("one_hot_score", 32'($signed(sc[1])), 1);

    run_vec(6'b000101, 0);
    chk("tie_class", 32'(cls[1]), 0);
    chk("tie_score", 32'($signed(sc[1])), 1);

    run_vec(6'b000000, 0);
    chk("zero_class", 32'(cls[1]), 0);
    chk("zero_score", 32'($signed(sc[1])), 0);

    run_vec(6'b110010, 5);
    run_vec(6'b011011, 0);

    in_valid  = 1'b1;
    hidden_in = 6'b111111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", 32'(ir[2]), 1);
    chk("mid_rst_valid", 32'(ov[2]), 0);
    chk("mid_rst_class", 32'(cls[2]), 0);
    chk("mid_rst_score", 32'(sc[2]), 0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 16; c++) begin
        tick();
        if (ov[2] !== 1'b0 || ir[2] !== 1'b1) seen++;
      end
      chk("no_stale_out", seen, 0);
    end
    run_vec(6'b101010, 0);

    for (int n = 0; n < 24; n++)
      run_vec(NH'($urandom), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
